hyperbus_burst_ctrl: RTL and testbench



---
 rtl/hyperbus_burst_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_hyperbus_burst_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_burst_ctrl.sv
// Burst controller between a user command/stream interface and the Hyperbus native port.
// TX/RX word FIFOs decouple the user side; one Hyperbus request covers a whole burst.
module hyperbus_burst_ctrl #(
    parameter int USER_DATA_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int ASIZE           = 2,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic [USER_DATA_WIDTH-1:0] tx_dat,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [USER_DATA_WIDTH-1:0] rx_dat,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic                       done,
    output logic                       err,
    output logic                       busy,
    output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic                       hbus_rrq,
    output logic                       hbus_wrq,
    input  logic                       hbus_ready,
    input  logic                       hbus_valid,
    input  logic                       hbus_busy,
    output logic [2:0]                 dbg_state_o
);
    localparam int DEPTH = 1 << ASIZE;
    localparam int RATIO = USER_DATA_WIDTH / HBUS_DATA_WIDTH;
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = ((LEN_WIDTH > ASIZE + 1) ? LEN_WIDTH : ASIZE + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WRITE, S_READ, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       cmd_ready_q, cmd_ready_d, done_q, done_d, err_q, err_d;
    logic                       busy_q, busy_d, wrq_q, wrq_d, rrq_q, rrq_d, we_q, we_d;
    logic [HBUS_ADDR_WIDTH-1:0] adr_q, adr_d, hadr_q, hadr_d;
    logic [LEN_WIDTH-1:0]       len_q, len_d, words_q, words_d;
    logic [BW-1:0]              beat_q, beat_d;
    logic [USER_DATA_WIDTH-1:0] asm_q, asm_d;

    logic [USER_DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [USER_DATA_WIDTH-1:0] rx_mem [DEPTH];
    logic [ASIZE-1:0]           tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [ASIZE:0]             tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                       tx_ready_q, rx_valid_q;
    logic                       tx_push, tx_pop, rx_push, rx_pop;
    logic [USER_DATA_WIDTH-1:0] tx_head;

    logic accept, len_bad, arm_ok, last_beat, last_word;

    // Every channel transfers on the cycle where valid and ready are both high at the edge;
    // ready never depends combinationally on valid, so producers may hold valid indefinitely.
    assign accept    = cmd_valid & cmd_ready_q;
    assign len_bad   = (cmd_len == '0) || (CW'(cmd_len) > CW'(DEPTH));
    assign arm_ok    = ~hbus_busy & (we_q ? (CW'(tx_cnt_q) >= CW'(len_q))
                                          : (CW'(DEPTH) - CW'(rx_cnt_q) >= CW'(len_q)));
    assign last_beat = (beat_q == BW'(RATIO - 1));
    assign last_word = (words_q == LEN_WIDTH'(1));
    assign tx_push   = tx_valid & tx_ready_q;
    assign rx_pop    = rx_valid_q & rx_ready;
    assign tx_head   = tx_mem[tx_rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            wrq_q       <= 1'b0;
            rrq_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            hadr_q      <= '0;
            len_q       <= '0;
            words_q     <= '0;
            beat_q      <= '0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            wrq_q       <= wrq_d;
            rrq_q       <= rrq_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            hadr_q      <= hadr_d;
            len_q       <= len_d;
            words_q     <= words_d;
            beat_q      <= beat_d;
            asm_q       <= asm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !len_bad) state_d = S_ARM;
            S_ARM:   if (arm_ok) state_d = we_q ? S_WRITE : S_READ;
            S_WRITE: if (hbus_ready && last_beat && last_word) state_d = S_DONE;
            S_READ:  if (hbus_valid && last_beat && last_word) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        adr_d   = adr_q;
        len_d   = len_q;
        hadr_d  = hadr_q;
        wrq_d   = wrq_q;
        rrq_d   = rrq_q;
        words_d = words_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        err_d   = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                we_d  = cmd_we;
                adr_d = cmd_adr;
                len_d = cmd_len;
                err_d = len_bad;
            end
            S_ARM: if (arm_ok) begin
                hadr_d  = adr_q;
                wrq_d   = we_q;
                rrq_d   = ~we_q;
                beat_d  = '0;
                words_d = len_q;
            end
            S_WRITE: if (hbus_ready) begin
                beat_d = last_beat ? '0 : beat_q + BW'(1);
                if (last_beat) begin
                    tx_pop  = 1'b1;
                    words_d = words_q - LEN_WIDTH'(1);
                    if (last_word) wrq_d = 1'b0;
                end
            end
            S_READ: if (hbus_valid) begin
                asm_d  = (asm_q << HBUS_DATA_WIDTH) | USER_DATA_WIDTH'(hbus_dat_i);
                beat_d = last_beat ? '0 : beat_q + BW'(1);
                if (last_beat) begin
                    rx_push = 1'b1;
                    words_d = words_q - LEN_WIDTH'(1);
                    if (last_word) rrq_d = 1'b0;
                end
            end
            default: ;
        endcase
        // The error cycle briefly withholds cmd_ready so the pulse pairs with one command.
        cmd_ready_d = (state_d == S_IDLE) && !err_d;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (ASIZE+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (ASIZE+1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (ASIZE+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (ASIZE+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= tx_dat;
        if (rx_push) rx_mem[rx_wptr_q] <= asm_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            tx_ready_q <= 1'b0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + ASIZE'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + ASIZE'(1);
            if (rx_push) rx_wptr_q <= rx_wptr_q + ASIZE'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + ASIZE'(1);
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_ready_q <= (tx_cnt_d != (ASIZE+1)'(DEPTH));
            rx_valid_q <= (rx_cnt_d != '0);
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign tx_ready    = tx_ready_q;
    assign rx_valid    = rx_valid_q;
    assign rx_dat      = rx_mem[rx_rptr_q];
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign hbus_adr_o  = hadr_q;
    assign hbus_wrq    = wrq_q;
    assign hbus_rrq    = rrq_q;
    assign hbus_dat_o  = (state_q == S_WRITE)
                       ? tx_head[USER_DATA_WIDTH-1 - HBUS_DATA_WIDTH*int'(beat_q) -: HBUS_DATA_WIDTH]
                       : '0;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Directed bench for hyperbus_burst_ctrl: writes, reads, backpressure, illegal commands, reset.
module tb_hyperbus_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic [31:0] tx_dat, rx_dat;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic        done, err, busy;
    logic [31:0] hbus_adr_o;
    logic [15:0] hbus_dat_o, hbus_dat_i;
    logic        hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;
    logic [2:0]  dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    hyperbus_burst_ctrl #(
        .USER_DATA_WIDTH(32), .HBUS_DATA_WIDTH(16), .HBUS_ADDR_WIDTH(32),
        .ASIZE(2), .LEN_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .done(done), .err(err), .busy(busy),
        .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_dat_i(hbus_dat_i),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq),
        .hbus_ready(hbus_ready), .hbus_valid(hbus_valid), .hbus_busy(hbus_busy),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic push_tx(input logic [31:0] w);
        check("tx_ready_before_push", tx_ready, 1);
        tx_dat   = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [31:0] w);
        logic [15:0] hi, lo;
        hi = w[31:16];
        lo = w[15:0];
        check("wrq_beat_hi", hbus_wrq, 1);
        check("dat_beat_hi", hbus_dat_o, hi);
        tick();
        check("wrq_beat_lo", hbus_wrq, 1);
        check("dat_beat_lo", hbus_dat_o, lo);
        tick();
    endtask

    task automatic feed_beat(input logic [15:0] b);
        hbus_valid = 1'b1;
        hbus_dat_i = b;
        tick();
        hbus_valid = 1'b0;
    endtask

    // scoreboard drain
    task automatic drain_rx();
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rx_valid_drain", rx_valid, 1);
            check("rx_dat_drain", rx_dat, e);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        check("rx_empty_after_drain", rx_valid, 0);
    endtask

    initial begin
        logic [31:0] words [4];
        int gap;
        words[0] = 32'h0102_0304;
        words[1] = 32'h0506_0708;
        words[2] = 32'h090A_0B0C;
        words[3] = 32'h0D0E_0F10;

        rst = 1'b1;
        cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_len = '0;
        tx_dat = '0; tx_valid = 0; rx_ready = 0;
        hbus_dat_i = '0; hbus_ready = 0; hbus_valid = 0; hbus_busy = 0;
        repeat (2) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_wrq", hbus_wrq, 0);
        check("rst_rrq", hbus_rrq, 0);
        check("rst_adr", hbus_adr_o, 0);
        check("rst_dat", hbus_dat_o, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_tx_ready", tx_ready, 1);

        // two-word write, bus never stalls
        push_tx(32'hAABB_CCDD);
        push_tx(32'h1122_3344);
        hbus_ready = 1'b1;
        send_cmd(1'b1, 32'h100, 8'd2);
        check("w2_arm_busy", busy, 1);
        check("w2_arm_wrq", hbus_wrq, 0);
        check("w2_arm_cmd_ready", cmd_ready, 0);
        tick();
        check("w2_adr", hbus_adr_o, 32'h100);
        write_beats(32'hAABB_CCDD);
        write_beats(32'h1122_3344);
        check("w2_wrq_fall", hbus_wrq, 0);
        check("w2_done", done, 1);
        tick();
        check("w2_done_one_cycle", done, 0);
        check("w2_idle_cmd_ready", cmd_ready, 1);
        check("w2_idle_busy", busy, 0);

        // fill TX, offer a fifth word, then hold the request off with hbus_busy
        for (int i = 0; i < 4; i++) push_tx(words[i]);
        check("tx_full_ready", tx_ready, 0);
        tx_dat = 32'hDEAD_BEEF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx_full_still", tx_ready, 0);
        hbus_busy = 1'b1;
        send_cmd(1'b1, 32'h2000, 8'd4);
        repeat (3) begin
            tick();
            check("busy_hold_wrq", hbus_wrq, 0);
        end
        check("busy_hold_state_arm", dbg_state_o, 3'd1);
        hbus_busy = 1'b0;
        tick();
        check("w4_adr", hbus_adr_o, 32'h2000);
        for (int i = 0; i < 4; i++) write_beats(words[i]);
        check("w4_wrq_fall", hbus_wrq, 0);
        check("w4_done", done, 1);
        check("w4_tx_ready", tx_ready, 1);
        tick();

        // three-word read with random gaps between beats
        hbus_ready = 1'b0;
        check("r3_rx_empty", rx_valid, 0);
        send_cmd(1'b0, 32'h40, 8'd3);
        tick();
        check("r3_rrq", hbus_rrq, 1);
        check("r3_wrq", hbus_wrq, 0);
        check("r3_adr", hbus_adr_o, 32'h40);
        for (int b = 1; b <= 6; b++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                tick();
                check("r3_rrq_gap", hbus_rrq, 1);
            end
            if (b == 2) check("r3_rx_before_word", rx_valid, 0);
            feed_beat(16'(b));
            if (b == 2) begin
                check("r3_rx_after_word", rx_valid, 1);
                check("r3_rx_fwft", rx_dat, 32'h0001_0002);
            end
            if (b < 6) check("r3_rrq_held", hbus_rrq, 1);
        end
        check("r3_rrq_fall", hbus_rrq, 0);
        check("r3_done", done, 1);
        tick();
        check("r3_done_one_cycle", done, 0);
        exp_q.push_back(32'h0001_0002);
        exp_q.push_back(32'h0003_0004);
        exp_q.push_back(32'h0005_0006);
        drain_rx();

        // read that must wait for RX space
        send_cmd(1'b0, 32'h200, 8'd3);
        tick();
        for (int b = 10; b < 16; b++) feed_beat(16'(b));
        check("pre_done", done, 1);
        tick();
        send_cmd(1'b0, 32'h300, 8'd2);
        repeat (3) begin
            tick();
            check("space_hold_rrq", hbus_rrq, 0);
            check("space_hold_busy", busy, 1);
        end
        check("space_pop_dat", rx_dat, 32'h000A_000B);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("space_rrq_after_pop", hbus_rrq, 0);
        tick();
        check("space_rrq_go", hbus_rrq, 1);
        check("space_adr", hbus_adr_o, 32'h300);
        feed_beat(16'h0011);
        feed_beat(16'h0022);
        feed_beat(16'h0033);
        feed_beat(16'h0044);
        check("space_done", done, 1);
        tick();
        exp_q.push_back(32'h000C_000D);
        exp_q.push_back(32'h000E_000F);
        exp_q.push_back(32'h0011_0022);
        exp_q.push_back(32'h0033_0044);
        drain_rx();

        // illegal lengths
        send_cmd(1'b0, 32'h0, 8'd0);
        check("len0_err", err, 1);
        check("len0_cmd_ready", cmd_ready, 0);
        check("len0_busy", busy, 0);
        tick();
        check("len0_err_one_cycle", err, 0);
        check("len0_cmd_ready_back", cmd_ready, 1);
        check("len0_rrq", hbus_rrq, 0);
        send_cmd(1'b1, 32'h0, 8'd5);
        check("len5_err", err, 1);
        check("len5_busy", busy, 0);
        tick();
        check("len5_err_one_cycle", err, 0);
        check("len5_cmd_ready_back", cmd_ready, 1);
        check("len5_wrq", hbus_wrq, 0);

        // reset during a write after two of four beats
        push_tx(32'h1234_5678);
        push_tx(32'h9ABC_DEF0);
        hbus_ready = 1'b1;
        send_cmd(1'b1, 32'h500, 8'd2);
        tick();
        check("mid_wrq_up", hbus_wrq, 1);
        tick();
        tick();
        check("mid_wrq_beat3", hbus_wrq, 1);
        check("mid_dat_beat3", hbus_dat_o, 16'h9ABC);
        rst = 1'b1;
        #1;
        check("mid_rst_wrq_async", hbus_wrq, 0);
        check("mid_rst_done", done, 0);
        tick();
        check("mid_rst_done_held", done, 0);
        rst = 1'b0;
        tick();
        check("mid_post_done", done, 0);
        check("mid_post_cmd_ready", cmd_ready, 1);
        send_cmd(1'b1, 32'h600, 8'd1);
        repeat (3) begin
            tick();
            check("mid_tx_empty_wrq", hbus_wrq, 0);
        end
        push_tx(32'h5555_AAAA);
        check("mid_push_wrq", hbus_wrq, 0);
        tick();
        check("mid_adr", hbus_adr_o, 32'h600);
        write_beats(32'h5555_AAAA);
        check("mid_final_done", done, 1);
        tick();
        check("mid_final_done_low", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
